// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan scheduler.
//   NUM_DIGITS / NUM_SRC / NIB_W : display geometry and requester count
//   onehot8(idx)                 : one-hot digit select for a 3-bit digit index
//   lz_mask(word)                : per-digit leading-zero blank mask for a 32-bit word
package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_SRC    = 4;
    localparam int NIB_W      = 4;

    typedef logic [1:0] src_idx_t;
    typedef logic [2:0] digit_idx_t;

    function automatic logic [NUM_DIGITS-1:0] onehot8(input digit_idx_t idx);
        return 8'b1 << idx;
    endfunction

    // Bit k is set when every nibble from digit k upward is zero. Digit 0 is
    // always lit, so bit 0 is forced low.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [31:0] word);
        logic [NUM_DIGITS-1:0] mask;
        mask = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            mask[k] = ((word >> (NIB_W * k)) == 32'd0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot prescaler. Counts 0..SCAN_DIV-1 and wraps; scan_tick is high for
// the single cycle in which the count sits at its terminal value.
//   clk, rst  : clock and asynchronous active-high reset
//   scan_tick : one-cycle pulse, once every SCAN_DIV cycles
module scan_timer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic scan_tick
);

    localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);

    logic [PCNT_W-1:0] pcnt_reg;

    assign scan_tick = (pcnt_reg == PCNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else if (scan_tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_sched.sv
// Scan scheduler and display arbiter for an 8-digit multiplexed display.
// Four requesters share the display with frame-aligned round-robin and a
// minimum dwell; the owner's word is snapshotted once per frame.
//   clk, rst     : clock, asynchronous active-high reset
//   src_req      : per-source level request
//   src_data     : source i word at [32i+31:32i]
//   blank_en     : enable leading-zero blanking
//   src_grant    : one-hot current owner (zero when none)
//   enable       : active-low one-hot digit strobes
//   digit_val    : nibble for the active digit
//   digit_blank  : active digit must be dark
//   frame_tick   : one-cycle pulse following each frame boundary
module disp_scan_sched
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DWELL    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [32*NUM_SRC-1:0] src_data,
    input  logic                  blank_en,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [NUM_DIGITS-1:0] enable,
    output logic [NIB_W-1:0]      digit_val,
    output logic                  digit_blank,
    output logic                  frame_tick
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);

    logic scan_tick;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .scan_tick (scan_tick)
    );

    // Per-source word view
    logic [31:0] src_word [NUM_SRC];
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_word
            assign src_word[gi] = src_data[32*gi +: 32];
        end
    endgenerate

    digit_idx_t      idx_reg;
    logic            has_owner_reg;
    src_idx_t        owner_reg;
    logic [DW-1:0]   dwell_cnt_reg;
    logic [31:0]     snap_reg;

    // Arbitration result, only committed at a frame boundary
    logic            keep;
    logic            arb_has;
    src_idx_t        arb_owner;
    logic [DW-1:0]   arb_dwell;
    logic [NUM_SRC-1:0] owner_oh;
    src_idx_t        base;
    src_idx_t        cand;

    always_comb begin
        owner_oh  = has_owner_reg ? (NUM_SRC'(1) << owner_reg) : '0;
        keep      = has_owner_reg && src_req[owner_reg] &&
                    (((src_req & ~owner_oh) == '0) || (dwell_cnt_reg < DWELL_MAX));
        arb_has   = 1'b0;
        arb_owner = owner_reg;
        arb_dwell = '0;
        base      = has_owner_reg ? owner_reg + 2'd1 : 2'd0;
        cand      = '0;
        if (keep) begin
            arb_has   = 1'b1;
            arb_dwell = (dwell_cnt_reg == DWELL_MAX) ? dwell_cnt_reg : dwell_cnt_reg + 1'b1;
        end else begin
            // Walk the search order backwards so the nearest requester wins.
            for (int j = NUM_SRC - 1; j >= 0; j--) begin
                cand = base + 2'(j);
                if (src_req[cand]) begin
                    arb_has   = 1'b1;
                    arb_owner = cand;
                end
            end
        end
    end

    logic            boundary;
    digit_idx_t      idx_next;
    logic            has_owner_next;
    src_idx_t        owner_next;
    logic [DW-1:0]   dwell_next;
    logic [31:0]     snap_next;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic            blank_next;
    logic [NIB_W-1:0] val_next;
    logic [NUM_SRC-1:0] grant_next;

    always_comb begin
        boundary       = scan_tick && (idx_reg == 3'd7);
        idx_next       = idx_reg + 3'd1;
        has_owner_next = has_owner_reg;
        owner_next     = owner_reg;
        dwell_next     = dwell_cnt_reg;
        snap_next      = snap_reg;
        if (boundary) begin
            has_owner_next = arb_has;
            owner_next     = arb_owner;
            dwell_next     = arb_dwell;
            // No owner keeps the old snapshot; the display is fully blanked anyway.
            if (arb_has) begin
                snap_next = src_word[arb_owner];
            end
        end
        grant_next = has_owner_next ? (NUM_SRC'(1) << owner_next) : '0;
        // Digit 0 of a new frame must already see the new snapshot.
        blank_mask = lz_mask(snap_next);
        blank_next = !has_owner_next || (blank_en && blank_mask[idx_next]);
        val_next   = snap_next[NIB_W*idx_next +: NIB_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg       <= 3'd7;
            has_owner_reg <= 1'b0;
            owner_reg     <= '0;
            dwell_cnt_reg <= '0;
            snap_reg      <= '0;
            src_grant     <= '0;
            enable        <= 8'hFF;
            digit_val     <= '0;
            digit_blank   <= 1'b1;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (scan_tick) begin
                idx_reg     <= idx_next;
                enable      <= ~onehot8(idx_next);
                digit_val   <= val_next;
                digit_blank <= blank_next;
            end
            if (boundary) begin
                has_owner_reg <= has_owner_next;
                owner_reg     <= owner_next;
                dwell_cnt_reg <= dwell_next;
                snap_reg      <= snap_next;
                src_grant     <= grant_next;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_sched.sv
// Self-checking bench for disp_scan_sched (SCAN_DIV=4, DWELL=2). A slot-level
// model derives expected outputs from elapsed edge counts; a negedge process
// compares every cycle, and directed phases pin literal values.
module tb_disp_scan_sched;

    localparam int SCAN_DIV = 4;
    localparam int DWELL    = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   src_req = '0;
    logic [127:0] src_data = '0;
    logic         blank_en = 1'b0;
    logic [3:0]   src_grant;
    logic [7:0]   enable;
    logic [3:0]   digit_val;
    logic         digit_blank;
    logic         frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_scan_sched #(.SCAN_DIV(SCAN_DIV), .DWELL(DWELL)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_data    (src_data),
        .blank_en    (blank_en),
        .src_grant   (src_grant),
        .enable      (enable),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .frame_tick  (frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input int owner, input int dwell, input logic [3:0] req);
        int c;
        if (owner >= 0 && req[owner] &&
            (((req & ~(4'b1 << owner)) == 4'b0) || dwell < DWELL - 1))
            return owner;
        for (int j = 1; j <= 4; j++) begin
            c = (owner < 0) ? (j - 1) : (owner + j) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
        return 32'(d >> (32 * i));
    endfunction

    int          m_n;      // rising edges since reset release
    int          m_owner;  // -1 = none
    int          m_dwell;
    logic [31:0] m_snap;
    logic [7:0]  exp_enable;
    logic [3:0]  exp_val;
    logic [3:0]  exp_grant;
    logic        exp_blank;
    logic        exp_ft;

    // Slot s (starting at edge s*SCAN_DIV) displays digit (s-1) mod 8.
    int          c_digit;
    logic        c_tick;
    logic        c_bound;
    int          c_own;
    int          c_dwell;
    logic [31:0] c_snap;

    assign c_tick  = ((m_n + 1) % SCAN_DIV) == 0;
    assign c_digit = ((m_n + 1) / SCAN_DIV + 7) % 8;
    assign c_bound = c_tick && (c_digit == 0);
    assign c_own   = c_bound ? pick(m_owner, m_dwell, src_req) : m_owner;
    assign c_dwell = !c_bound ? m_dwell :
                     (c_own >= 0 && c_own == m_owner) ? ((m_dwell + 1 > DWELL - 1) ? DWELL - 1 : m_dwell + 1) : 0;
    assign c_snap  = (c_bound && c_own >= 0) ? word_of(src_data, c_own) : m_snap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n        <= 0;
            m_owner    <= -1;
            m_dwell    <= 0;
            m_snap     <= '0;
            exp_enable <= 8'hFF;
            exp_val    <= '0;
            exp_grant  <= '0;
            exp_blank  <= 1'b1;
            exp_ft     <= 1'b0;
        end else begin
            m_n    <= m_n + 1;
            exp_ft <= c_bound;
            if (c_tick) begin
                exp_enable <= ~(8'b1 << c_digit);
                exp_val    <= 4'(c_snap >> (4 * c_digit));
                exp_blank  <= (c_own < 0) ||
                              (blank_en && c_digit > 0 && ((c_snap >> (4 * c_digit)) == 32'd0));
            end
            if (c_bound) begin
                m_owner   <= c_own;
                m_dwell   <= c_dwell;
                m_snap    <= c_snap;
                exp_grant <= (c_own < 0) ? 4'b0 : 4'(4'b1 << c_own);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("enable", 32'(enable), 32'(exp_enable));
            chk("digit_val", 32'(digit_val), 32'(exp_val));
            chk("digit_blank", 32'(digit_blank), 32'(exp_blank));
            chk("src_grant", 32'(src_grant), 32'(exp_grant));
            chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
        end
    end

    // Park at the negedge following rising edge n (counted from reset release).
    task automatic wait_edge(input int n);
        while (m_n < n) @(negedge clk);
    endtask

    logic [7:0] t_en     [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [3:0] t_single [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] t_lz_val [8] = '{4'hB, 4'hA, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       t_lz_bl  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] t_cont   [5] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001};

    initial begin
        // ---- reset / idle scan ----
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_edge(k);
            chk("rst_enable", 32'(enable), 32'h FF);
            chk("rst_blank", 32'(digit_blank), 32'd1);
            chk("rst_grant", 32'(src_grant), 32'd0);
        end
        for (int s = 1; s <= 9; s++) begin
            wait_edge(4 * s);
            chk("scan_enable", 32'(enable), 32'(t_en[(s - 1) % 8]));
            chk("idle_blank", 32'(digit_blank), 32'd1);
            if (s == 1) begin
                chk("ft_first", 32'(frame_tick), 32'd1);
                wait_edge(5);
                chk("ft_drop", 32'(frame_tick), 32'd0);
            end
            if (s == 9) chk("ft_second", 32'(frame_tick), 32'd1);
        end

        // ---- single source, no blanking ----
        wait_edge(40);
        src_req  = 4'b0010;
        src_data = {32'h0, 32'h0, 32'h1234ABCD, 32'h0};
        blank_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_edge(68 + 4 * k);
            chk("single_grant", 32'(src_grant), 32'b0010);
            chk("single_val", 32'(digit_val), 32'(t_single[k]));
            chk("single_blank", 32'(digit_blank), 32'd0);
        end

        // ---- leading-zero blanking ----
        src_data = {32'h0, 32'h0, 32'h000012AB, 32'h0};
        blank_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_edge(100 + 4 * k);
            chk("lz_val", 32'(digit_val), 32'(t_lz_val[k]));
            chk("lz_blank", 32'(digit_blank), 32'(t_lz_bl[k]));
        end
        src_data = '0;
        for (int k = 0; k < 8; k++) begin
            wait_edge(132 + 4 * k);
            chk("zero_val", 32'(digit_val), 32'd0);
            chk("zero_blank", 32'(digit_blank), (k == 0) ? 32'd0 : 32'd1);
        end

        // ---- contention from reset ----
        rst = 1'b1;
        @(negedge clk);
        src_req  = 4'b0101;
        src_data = {32'h0, 32'h22222222, 32'h0, 32'h87654321};
        blank_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            wait_edge(4 + 32 * f);
            chk("cont_grant", 32'(src_grant), 32'(t_cont[f]));
            if (f == 2 || f == 4) chk("cont_dwell", 32'(dut.dwell_cnt_reg), 32'd0);
        end

        // ---- owner drops mid-frame at digit 3 ----
        wait_edge(144);
        chk("drop_at_idx3", 32'(enable), 32'hF7);
        src_req = 4'b0100;
        for (int k = 4; k < 8; k++) begin
            wait_edge(132 + 4 * k);
            chk("drop_val", 32'(digit_val), 32'(k + 1));
            chk("drop_grant", 32'(src_grant), 32'b0001);
        end
        wait_edge(164);
        chk("drop_newgrant", 32'(src_grant), 32'b0100);
        chk("drop_newval", 32'(digit_val), 32'h2);

        // ---- asynchronous reset mid-frame at digit 5 ----
        wait_edge(184);
        chk("pre_rst_enable", 32'(enable), 32'hDF);
        #2 rst = 1'b1;
        #1;
        chk("arst_enable", 32'(enable), 32'hFF);
        chk("arst_grant", 32'(src_grant), 32'd0);
        chk("arst_blank", 32'(digit_blank), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edge(3);
        chk("post_rst_hold", 32'(enable), 32'hFF);
        wait_edge(4);
        chk("post_rst_first", 32'(enable), 32'hFE);
        chk("post_rst_grant", 32'(src_grant), 32'b0100);
        wait_edge(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_sched.md
# disp_scan_sched

Scan scheduler and display arbiter for the board's 8-digit multiplexed seven-segment display. It shares the display between up to four 32-bit requesters, such as PC, ALU result, register probe and memory probe, using frame-aligned round-robin with a minimum dwell time. It snapshots the granted word once per frame and drives the digit strobes and per-digit nibble plus blank flag. The existing hex seven-segment decoders and segment OR-mux sit downstream and are unchanged.

## Interface
- SCAN_DIV, 100000: clk cycles per digit slot; legal range ≥2.
- DWELL, 8: minimum frames a granted source keeps the display while others request; legal range ≥1.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_req  in  4  per-source display request (level).
- src_data  in  128  source i word at [32i+31:32i].
- blank_en  in  1  enables leading-zero blanking.
- src_grant  out  4  one-hot owner, all zero when no owner; registered.
- enable  out  8  digit strobes, active-low one-hot; registered.
- digit_val  out  4  nibble for the active digit; registered.
- digit_blank  out  1  active digit must be dark; registered.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `scan_tick` is asserted when pcnt==SCAN_DIV-1.
- Digit index `idx` (3 bits) resets to 7. On each scan_tick: idx←idx+1 mod 8, enable←~(1<<idx_next), and digit_val/digit_blank are loaded for idx_next.
- A frame boundary is a scan_tick with idx==7. The first scan_tick after reset is therefore a boundary.
- At each boundary, in this order:
  1. Arbitrate.
  2. Latch `snap` ← src_data word of the new owner. Snap is unchanged if there is no owner.
  3. Digit 0 of the new frame uses the new snap.
  4. Pulse frame_tick.
- Arbitration:
  - Keep the owner if it still requests and either no other source requests, or dwell_cnt<DWELL-1. When keeping, dwell_cnt increments, saturating at DWELL-1.
  - Otherwise grant the first requesting source searching owner+1, owner+2, … mod 4, and clear dwell_cnt to 0. The search starts at source 0 when there is no owner.
  - No requesters leaves no owner: src_grant=0.
- Blanking:
  - digit_blank=1 for every digit while there is no owner.
  - Otherwise, with blank_en=1, digit k>0 is blanked when snap[31:4k] is all zero.
  - Digit 0 is never blanked.
- digit_val is snap[4k+3:4k] regardless of blank.
- Requests and src_data changing mid-frame have no effect until the next boundary.

## Timing
- Reset values: enable=8'hFF, digit_val=0, digit_blank=1, src_grant=0, frame_tick=0, pcnt=0, idx=7, dwell_cnt=0, snap=0.
- First digit strobe: enable=8'hFE, SCAN_DIV cycles after reset release.
- enable, digit_val, digit_blank and src_grant all change on the same edge. There is no output skew between them.
- One frame is 8·SCAN_DIV cycles.
- Request-to-grant latency: at most one frame plus (DWELL-1) frames of contention per ahead-of-turn owner.
- Owner dropping src_req: display continues with the old snap until the boundary, then switches.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). No partial frame resumes.

## Structure
- Package disp_pkg holds:
  - NUM_DIGITS=8, NUM_SRC=4, NIB_W=4.
  - `onehot8(idx)` function.
  - `lz_mask(word)` function returning the 8-bit blank mask.
- One sub-module, scan_timer, holds the prescaler and emits scan_tick.
- Arbiter, dwell counter, snapshot and output registers stay in the top module.

## Test plan
- Reset/scan: SCAN_DIV=4, src_req=0.
  - Outputs hold the reset values through 3 cycles.
  - enable then steps FE, FD, FB, … 7F, FE every 4 cycles.
  - digit_blank=1 throughout; frame_tick pulses every 32 cycles.
- Single source: src_req=4'b0010, word1=32'h1234ABCD, blank_en=0.
  - src_grant=0010 at the first boundary.
  - digit_val sequence D, C, B, A, 4, 3, 2, 1; no blanks.
- Leading zeros: word=32'h000012AB, blank_en=1.
  - digits 0–3 show B, A, 2, 1 with blank=0; digits 4–7 have blank=1.
  - Word 0 shows only digit 0 (value 0).
- Contention: DWELL=2, src_req=4'b0101 from reset.
  - Grant sequence per frame: 0001, 0001, 0100, 0100, 0001…
  - dwell_cnt is 0 at each switch.
- Drop mid-frame: owner 0 deasserts at idx=3 while src 2 requests.
  - idx 4–7 still show word0; grant moves to 0100 at the boundary.
- Async reset asserted mid-frame at idx=5.
  - Same cycle: enable=FF, src_grant=0, digit_blank=1.
  - After release: enable=FE exactly SCAN_DIV cycles later.
